// File: rtl/toggle_sync_pkg.sv
// Shared types and helpers for the toggle-handshake request controller.
// Holds the FSM state encoding and the counter-width helper.
package toggle_sync_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        ERR      = 2'd2
    } tsc_state_t;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage : toggle_sync_pkg

// File: rtl/sync_dff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Reset is synchronous and active-low; both stages clear to zero.
module sync_dff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync_dff

// File: rtl/toggle_req_ctrl.sv
// Source-side sequencer for a toggle-handshake CDC: captures a word, flips
// req_tgl and waits for the far domain to echo it back on ack_tgl_async.
module toggle_req_ctrl
    import toggle_sync_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] xfer_data,
    output logic              req_tgl,
    input  logic              ack_tgl_async,
    output logic              busy,
    output logic              done_pulse,
    output logic              timeout_pulse
);

    localparam int              TO_W    = clog2_min1(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    tsc_state_t        state_q;
    logic              req_tgl_q;
    logic [DATA_W-1:0] xfer_data_q;
    logic              done_q;
    logic              timeout_q;
    logic [TO_W-1:0]   cnt_q;

    logic ack_sync;
    logic match;

    sync_dff #(
        .WIDTH (1)
    ) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (ack_tgl_async),
        .q_o   (ack_sync)
    );

    // The handshake is balanced whenever the echoed toggle equals our request.
    assign match    = (ack_sync == req_tgl_q);
    assign in_ready = (state_q == IDLE) && match;
    assign busy     = (state_q != IDLE);

    // NOTE: every register here is sequential state, so only non-blocking
    // assignments are used; the pulses default low and are set for one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_tgl_q   <= 1'b0;
            xfer_data_q <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        xfer_data_q <= in_data;
                        req_tgl_q   <= ~req_tgl_q;
                        cnt_q       <= '0;
                        state_q     <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (cnt_q != TO_MAX) begin
                        cnt_q <= cnt_q + TO_W'(1);
                    end
                    // An ack arriving on the last counted cycle beats the timeout.
                    if (match) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
                        timeout_q <= 1'b1;
                        state_q   <= ERR;
                    end
                end
                ERR: begin
                    if (match) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign xfer_data     = xfer_data_q;
    assign req_tgl       = req_tgl_q;
    assign done_pulse    = done_q;
    assign timeout_pulse = timeout_q;

endmodule : toggle_req_ctrl
